mem_stage_pipe: RTL
===================

Name: mem_stage_pipe

Overview:
Parametrised data-memory stage for the five-stage RISC-V pipeline.
- Performs byte/half/word/dword loads and stores with sign/zero extension.
- Registers the write-back result behind a valid/ready handshake.
- Continuously scans a memory-mapped video window into a shadow register for display.
- Sits between EX and WB and replaces the fixed 64-bit, combinational-read data stage.

Parameters:
- XLEN, 64, datapath width in bits; 32 or 64.
- DMEM_BYTES, 128, data memory size in bytes; power of two.
- VMEM_BYTES, 8, video window size in bytes; power of two, ≤ DMEM_BYTES.
- VMEM_BASE, 120, byte address of the video window; VMEM_BASE + VMEM_BYTES ≤ DMEM_BYTES.

Ports:
- sys_clk, in, 1, clock, rising edge.
- sys_rst, in, 1, asynchronous active-high reset.
- req_valid, in, 1, EX presents a request.
- req_ready, out, 1, stage accepts a request this cycle.
- wb_select, in, 2, 00 alu_res; 01 load data; 10 pc_plus_4; 11 alu_res.
- pc_plus_4, in, XLEN, link value.
- alu_res, in, XLEN, effective address / ALU result.
- store_data, in, XLEN, store data, LSB-aligned.
- mem_size, in, 2, 0 byte; 1 half; 2 word; 3 dword (3 is illegal when XLEN=32).
- load_unsigned, in, 1, zero-extend the load when 1.
- write_enable, in, 1, request is a store.
- rsp_valid, out, 1, write_back_data is valid.
- rsp_ready, in, 1, WB consumes the response.
- write_back_data, out, XLEN, registered result.
- mem_fault, out, 1, registered with the response; access was misaligned or out of range.
- vmem_data, out, 8*VMEM_BYTES, video shadow; byte i mirrors dmem[VMEM_BASE+i].

Behaviour:
- Reset (async, while sys_rst=1):
  - rsp_valid=0, write_back_data=0, mem_fault=0.
  - Scan counter=0, vmem_data=0.
  - dmem contents are not reset.
- Handshake:
  - req_ready = !rsp_valid || rsp_ready (single output register, no skid).
  - Accept occurs when req_valid && req_ready.
  - On accept, the result is registered. Load-to-use latency is exactly 1 cycle: rsp_valid rises on the edge after accept.
  - rsp_valid and data hold stable while rsp_ready=0.
  - rsp_valid clears when rsp_ready=1 and there is no new accept; back-to-back accepts give 1 response per cycle.
- Access size: N = 1 << mem_size bytes. Address = alu_res[log2(DMEM_BYTES)-1:0]; upper bits are ignored.
- Fault: mem_fault=1 when the address is not N-aligned, or when mem_size=3 with XLEN=32.
  - On fault: no dmem write, write_back_data=0 regardless of wb_select.
  - The response is still produced, so the pipeline never stalls.
- Store (accept && write_enable && !fault): writes bytes addr..addr+N-1 = store_data[8N-1:0], little-endian, at the accepting edge.
- Load data (wb_select=01):
  - Bytes addr..addr+N-1, little-endian.
  - Sign-extended to XLEN from bit 8N-1 unless load_unsigned=1; dword is unextended.
  - A load reads memory state before any store in the same accept; there is only one access per cycle, so no conflict.
- Other wb_select values select the combinational source, registered with the same 1-cycle latency.
- Video scan:
  - A log2(VMEM_BYTES)-bit counter increments every cycle, wrapping VMEM_BYTES-1 → 0.
  - Each edge: vmem byte[cnt] <= dmem[VMEM_BASE+cnt].
  - A store into the window is visible on vmem_data within VMEM_BYTES+1 cycles.
  - Scanning runs regardless of the handshake.
- Reset mid-operation: an in-flight response is dropped. A store is committed only if its accepting edge occurred before reset asserted.

Optional Feature:
MEM_MISALIGN_SPLIT_EN
- Defined:
  - A misaligned access is performed byte-wise with address wrap modulo DMEM_BYTES.
  - mem_fault is raised only for an illegal size.
  - Latency is unchanged (single cycle, byte-lane RAM).
- Undefined: misaligned accesses fault as described in Behaviour.

Decomposition:
- Shared package/include para.v holds:
  - wb_select encodings WB_ALU, WB_MEM, WB_PC.
  - mem_size encodings SZ_B, SZ_H, SZ_W, SZ_D.
  - Default XLEN.
- One natural sub-module, load_extend: combinational size/sign extension from the raw dword to XLEN. It is reusable by a future cache.

Test Plan:
1. Store dword 0x8877665544332211 at address 0, then load byte unsigned at address 7 → 0x88; load byte signed at 7 → 0xFFFFFFFFFFFFFF88; load half signed at 6 → 0xFFFFFFFFFFFF8877.
2. Store word 0xDEADBEEF at address 2 (misaligned) → mem_fault=1, write_back_data=0, memory unchanged. With MEM_MISALIGN_SPLIT_EN: bytes 2..5 updated, mem_fault=0.
3. Hold rsp_ready=0 for 3 cycles with req_valid=1 → req_ready=0, output stable; release → in-order responses, no loss or duplication.
4. Store byte 0xA5 at address 123 → vmem_data[31:24]=0xA5 within 9 cycles; other bytes unchanged.
5. wb_select=10, pc_plus_4=0x1004 → write_back_data=0x1004 one cycle after accept; wb_select=00 returns alu_res.
6. Assert sys_rst asynchronously mid-burst → rsp_valid, write_back_data and vmem_data go to 0 immediately; the scan restarts at byte 0 after release.

Source files
------------

// File: rtl/mem_stage_pipe_pkg.sv
// Shared definitions for the data-memory stage and its helpers.
//   - wb_select encodings (WB_ALU, WB_MEM, WB_PC, WB_ALU_ALT)
//   - mem_size encodings (SZ_B, SZ_H, SZ_W, SZ_D)
//   - default datapath width
//   - byte-enable helper for a given access size
package mem_stage_pipe_pkg;

  localparam int XLEN_DEFAULT = 64;

  typedef enum logic [1:0] {
    WB_ALU     = 2'b00,
    WB_MEM     = 2'b01,
    WB_PC      = 2'b10,
    WB_ALU_ALT = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } mem_size_e;

  // Lane mask relative to the access base address: N = 1 << size bytes.
  function automatic logic [7:0] size_byte_mask(input logic [1:0] sz);
    logic [7:0] m;
    case (sz)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_stage_pipe_load.sv
// load_extend: size selection and sign/zero extension of a raw
// little-endian dword (byte 0 = lowest address) to XLEN bits.
// Purely combinational so it can be reused behind a cache read path.
// Ports:
//   raw           in  64    bytes addr..addr+7, little-endian
//   mem_size      in  2     SZ_B/SZ_H/SZ_W/SZ_D
//   load_unsigned in  1     zero-extend when 1
//   load_data     out XLEN  extended result
module load_extend
  import mem_stage_pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [63:0]     raw,
  input  logic [1:0]      mem_size,
  input  logic            load_unsigned,
  output logic [XLEN-1:0] load_data
);

  logic signed [63:0] ext;
  logic               unused_ext;

  always_comb begin
    ext = $signed(raw);
    case (mem_size)
      SZ_B: ext = load_unsigned ? $signed({56'd0, raw[7:0]})
                                : 64'(signed'(raw[7:0]));
      SZ_H: ext = load_unsigned ? $signed({48'd0, raw[15:0]})
                                : 64'(signed'(raw[15:0]));
      SZ_W: ext = load_unsigned ? $signed({32'd0, raw[31:0]})
                                : 64'(signed'(raw[31:0]));
      default: ext = $signed(raw);  // dword is never extended
    endcase
  end

  assign load_data  = ext[XLEN-1:0];
  // Upper bits are dropped when XLEN=32.
  assign unused_ext = ^ext;

endmodule

// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe: data-memory stage between EX and WB.
//   Byte/half/word/dword loads and stores with sign/zero extension,
//   a one-deep registered response behind valid/ready, and a
//   continuous scan of the video window into a shadow register.
// Configuration macro: MEM_MISALIGN_SPLIT_EN
//   defined   - misaligned accesses are performed byte-wise with the
//               address wrapping modulo DMEM_BYTES; only an illegal size
//               faults.
//   undefined - misaligned accesses fault (no write, zero result).
// Ports:
//   sys_clk, sys_rst (async, active-high)
//   req_valid/req_ready           request handshake from EX
//   wb_select, pc_plus_4, alu_res, store_data, mem_size,
//   load_unsigned, write_enable   request payload
//   rsp_valid/rsp_ready           response handshake to WB
//   write_back_data, mem_fault    registered response
//   vmem_data                     video shadow, byte i = dmem[VMEM_BASE+i]
module mem_stage_pipe
  import mem_stage_pipe_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int DMEM_BYTES = 128,
  parameter int VMEM_BYTES = 8,
  parameter int VMEM_BASE  = 120
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              wb_select,
  input  logic [XLEN-1:0]         pc_plus_4,
  input  logic [XLEN-1:0]         alu_res,
  input  logic [XLEN-1:0]         store_data,
  input  logic [1:0]              mem_size,
  input  logic                    load_unsigned,
  input  logic                    write_enable,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [XLEN-1:0]         write_back_data,
  output logic                    mem_fault,
  output logic [8*VMEM_BYTES-1:0] vmem_data
);

  localparam int ADDR_W = $clog2(DMEM_BYTES);
  localparam int SCAN_W = $clog2(VMEM_BYTES);

  logic [7:0]              dmem [DMEM_BYTES];

  logic [ADDR_W-1:0]       addr;
  logic [7:0]              byte_en;
  logic                    illegal_size;
  logic                    access_fault;
  logic                    accept;
  logic                    store_fire;
  logic [63:0]             raw_dword;
  logic [63:0]             st_dword;
  logic [XLEN-1:0]         load_data;
  logic [XLEN-1:0]         result;
  logic                    unused_addr_hi;

  logic                    vld_p1;
  logic [XLEN-1:0]         wb_data_p1;
  logic                    fault_p1;

  logic [SCAN_W-1:0]       scan_cnt;
  logic [ADDR_W-1:0]       scan_addr;
  logic [8*VMEM_BYTES-1:0] vmem_p1;

  assign addr           = alu_res[ADDR_W-1:0];
  assign unused_addr_hi = ^alu_res[XLEN-1:ADDR_W];
  assign byte_en        = size_byte_mask(mem_size);
  assign illegal_size   = (XLEN == 32) && (mem_size == SZ_D);

`ifdef MEM_MISALIGN_SPLIT_EN
  assign access_fault = illegal_size;
`else
  logic misaligned;

  always_comb begin
    misaligned = 1'b0;
    case (mem_size)
      SZ_H:    misaligned = addr[0];
      SZ_W:    misaligned = |addr[1:0];
      SZ_D:    misaligned = |addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign access_fault = illegal_size | misaligned;
`endif

  // Single output register without skid: a new request is taken only
  // when the held response is leaving (or there is none).
  assign req_ready  = !vld_p1 || rsp_ready;
  assign accept     = req_valid && req_ready;
  // A store racing reset assertion is not committed.
  assign store_fire = accept && write_enable && !access_fault && !sys_rst;
  assign st_dword   = 64'(store_data);

  // Raw read of 8 consecutive bytes; the address adder wraps at
  // DMEM_BYTES, which is what the byte-wise misaligned mode needs.
  always_comb begin
    raw_dword = '0;
    for (int i = 0; i < 8; i++) begin
      raw_dword[8*i +: 8] = dmem[addr + ADDR_W'(i)];
    end
  end

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .raw          (raw_dword),
    .mem_size     (mem_size),
    .load_unsigned(load_unsigned),
    .load_data    (load_data)
  );

  always_comb begin
    result = alu_res;
    if (access_fault) begin
      result = '0;
    end else begin
      case (wb_select)
        WB_MEM:  result = load_data;
        WB_PC:   result = pc_plus_4;
        default: result = alu_res;
      endcase
    end
  end

  // ---- stage boundary: memory write at the accepting edge ----
  always_ff @(posedge sys_clk) begin
    if (store_fire) begin
      for (int i = 0; i < 8; i++) begin
        if (byte_en[i]) begin
          dmem[addr + ADDR_W'(i)] <= st_dword[8*i +: 8];
        end
      end
    end
  end

  // ---- stage boundary: registered write-back response ----
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      vld_p1     <= 1'b0;
      wb_data_p1 <= '0;
      fault_p1   <= 1'b0;
    end else if (accept) begin
      vld_p1     <= 1'b1;
      wb_data_p1 <= result;
      fault_p1   <= access_fault;
    end else if (rsp_ready) begin
      vld_p1     <= 1'b0;
    end
  end

  assign rsp_valid       = vld_p1;
  assign write_back_data = wb_data_p1;
  assign mem_fault       = fault_p1;

  // ---- stage boundary: video window scan, one byte per cycle ----
  assign scan_addr = ADDR_W'(VMEM_BASE) + ADDR_W'(scan_cnt);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      scan_cnt <= '0;
      vmem_p1  <= '0;
    end else begin
      scan_cnt                 <= scan_cnt + SCAN_W'(1);
      vmem_p1[8*scan_cnt +: 8] <= dmem[scan_addr];
    end
  end

  assign vmem_data = vmem_p1;

endmodule
